// File: rtl/product_uart_tx_if.sv
// Product-to-UART handshake: multiplier result in, start request in, board-level UART signals out.
interface product_uart_tx_if #(parameter int DATA_W = 512);
  logic              q_valid;
  logic [DATA_W-1:0] Q;
  logic              start;
  logic              Tx;
  logic              busy;
  logic              done;

  modport master (output q_valid, Q, start, input Tx, busy, done);
  modport slave  (input q_valid, Q, start, output Tx, busy, done);
endinterface

// File: rtl/product_uart_tx.sv
// Holds the multiplier product and streams it out as DATA_W/8 back-to-back 8N1 bytes, LSB byte first.
module product_uart_tx #(
  parameter int DATA_W       = 512,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic               clock,
  input  logic               reset,
  product_uart_tx_if.slave   bus
);
  localparam int BYTES  = DATA_W / 8;
  localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [2:0]          bit_idx, bit_idx_n;
  logic [BYTE_W-1:0]   byte_idx, byte_idx_n;
  logic [DATA_W-1:0]   shift, shift_n;
  logic [DATA_W-1:0]   hold, hold_n;
  logic                hold_valid, hold_valid_n;
  logic                done, done_n;
  logic                tick;
  logic                tx;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      shift      <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      byte_idx   <= byte_idx_n;
      shift      <= shift_n;
      hold       <= hold_n;
      hold_valid <= hold_valid_n;
      done       <= done_n;
    end
  end

  assign tick = (cnt == CNT_MAX);

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    bit_idx_n    = bit_idx;
    byte_idx_n   = byte_idx;
    shift_n      = shift;
    hold_n       = hold;
    hold_valid_n = hold_valid;
    done_n       = done;
    tx           = 1'b1;

    // The hold buffer is independent of the shifter, so a reload never corrupts a frame in flight.
    if (bus.q_valid) begin
      hold_n       = bus.Q;
      hold_valid_n = 1'b1;
    end

    if (state != IDLE) cnt_n = tick ? '0 : cnt + CNT_W'(1);

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (bus.start && (hold_valid || bus.q_valid)) begin
          shift_n    = bus.q_valid ? bus.Q : hold;
          done_n     = 1'b0;
          bit_idx_n  = '0;
          byte_idx_n = '0;
          state_n    = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (tick) state_n = DATA;
      end
      DATA: begin
        tx = shift[0];
        if (tick) begin
          shift_n   = shift >> 1;
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (byte_idx != BYTE_LAST) begin
            byte_idx_n = byte_idx + BYTE_W'(1);
            state_n    = START;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.Tx   = tx;
  assign bus.busy = (state != IDLE);
  assign bus.done = done;
endmodule

// File: doc/product_uart_tx.md
Name: product_uart_tx

Overview:
- Downstream stage of the 256x256 Karatsuba multiplier.
- Captures the 512-bit product when the multiplier flags it valid, and holds it in a buffer register.
- On a start request, serialises the held product over a UART line: 8N1 format, 64 bytes, least-significant byte first.
- Provides the board-level Tx, busy and done signals.

Parameters:
- DATA_W, 512: product width in bits; must be a multiple of 8.
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200 baud); legal range >= 2.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- q_valid  input  1  one-cycle pulse from the multiplier (out_valid); captures Q into the hold register.
- Q  input  DATA_W  product from the multiplier.
- start  input  1  request to transmit the held product; sampled only in IDLE.
- Tx  output  1  UART serial line; idles high.
- busy  output  1  high from the first cycle of the start bit through the last cycle of the final stop bit.
- done  output  1  sticky level; high after a complete frame, cleared by the next accepted start or by reset.

Behaviour:
- Reset (synchronous, active-high) forces:
  - Tx=1, busy=0, done=0, state=IDLE.
  - hold register=0, hold_valid=0.
  - baud counter=0, bit index=0, byte index=0.
- Reset mid-transmission aborts the frame. Tx is 1 on the cycle after reset is sampled.
- Hold buffer:
  - q_valid=1 loads Q into the hold register and sets hold_valid, in any state.
  - A load during transmission does not disturb the frame in flight; the shift register is separate.
- Start acceptance: only in IDLE, with start=1 and (hold_valid=1 or q_valid=1).
  - If q_valid=1 in the same cycle, the incoming Q is transmitted (bypass).
  - On acceptance: copy the data into the shift register, clear done, enter START on the next cycle.
  - start with nothing held is ignored; done is unchanged.
  - start while busy is ignored.
- State machine:
  - IDLE -> START on start acceptance.
  - START: Tx=0 for CLKS_PER_BIT cycles, then -> DATA.
  - DATA: Tx = shift[0] for CLKS_PER_BIT cycles per bit; shift right by 1 after each bit; after 8 bits -> STOP.
  - STOP: Tx=1 for CLKS_PER_BIT cycles. Then, if byte index < DATA_W/8-1, increment byte index and go to START (bytes back-to-back, no idle gap). Otherwise go to IDLE and set done=1.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. Width is clog2(CLKS_PER_BIT).
- Byte order and bit order:
  - Byte k carries Q[8k+7:8k], for k = 0..DATA_W/8-1.
  - Bits within a byte are sent LSB first.
- Latency:
  - Start-bit falling edge: 1 cycle after the start-acceptance edge.
  - Total frame: (DATA_W/8)*10*CLKS_PER_BIT cycles. For the defaults that is 64*10*868 = 555520 cycles.
- busy rises together with the first Tx=0. It falls on the same edge where done rises.
- hold_valid is not cleared by transmission, so the same product may be resent with a new start.

Test Plan:
1. CLKS_PER_BIT=4, reset held 2 cycles -> Tx=1, busy=0, done=0. start with no load -> no activity, done stays 0.
2. q_valid with Q=512'h...0201 (byte k = k+1), then start -> Tx decodes bytes 0x01,0x02,...,0x40 in order. Each frame is 0, 8 LSB-first bits, 1. Total busy = 2560 cycles, then done=1 and Tx=1.
3. During frame of scenario 2, q_valid with Q=all 0xFF, and a start pulse -> current frame unaffected. After done, a new start sends 64 bytes of 0xFF and done drops on acceptance.
4. q_valid and start in the same IDLE cycle with Q=512'hA5 repeated -> every transmitted byte is 0xA5 (bypass path).
5. Reset asserted at byte 10, mid data bit -> Tx=1 next cycle, busy=0, done=0, hold_valid=0. A subsequent start is ignored until a new q_valid.
6. CLKS_PER_BIT=2 boundary -> every bit lasts exactly 2 cycles. There is no gap between one byte's stop bit and the next byte's start bit.
